mult_booth_seq: RTL and testbench
=================================

# mult_booth_seq

Parametrised sequential radix-2 Booth multiplier, the multi-cycle successor to the single-cycle Booth multiplier in the CPU datapath. It computes a full 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned per request, retiring one Booth step per clock. A start/busy/done handshake lets the CPU's multiply/divide unit stall on it. Signed minimum × minimum needs no special-case path.

## Interface

- `WIDTH`, default 32. Operand width; legal range 4..64.
- `clk` input 1. Clock; all state changes on the rising edge.
- `reset` input 1. Asynchronous, active-low reset: asserting low clears all state immediately. Deassertion is synchronous to `clk` at the integration level.
- `start` input 1. Request strobe. Sampled only while `busy`=0.
- `sign` input 1. 1 = two's-complement operands; 0 = unsigned. Captured with `start`.
- `a` input WIDTH. Multiplicand. Captured with `start`.
- `b` input WIDTH. Multiplier. Captured with `start`.
- `busy` output 1. High while a multiplication is in progress.
- `done` output 1. One-cycle pulse when `z` has been updated with a new product.
- `z` output 2·WIDTH. Product. Holds its value until the next completion.

## Operation

- Internal width W1 = WIDTH+1. Both operands are extended to W1 bits at capture:
  - sign-extended when `sign`=1;
  - zero-extended when `sign`=0.
- Because of the extension, every product in both modes is exact in 2·W1 bits. `z` is the low 2·WIDTH bits of that product.
- State machine has two states, IDLE and RUN:
  - **IDLE**: on `start`=1, latch the multiplicand M (W1 bits) and −M (W1 bits). Load accumulator P = {W1 zeros, extended b, 1'b0} (2·W1+1 bits), clear the step counter, go to RUN.
  - **RUN**: each cycle, examine P[1:0]:
    - 01: P[hi] += M;
    - 10: P[hi] += −M;
    - 00/11: no add.
    - Then arithmetic-shift P right by 1 (replicate the MSB) and increment the counter.
  - **RUN exit**: after step W1, write z ← P[2·WIDTH:1], pulse `done`, and return to IDLE.
- Adds are modulo 2^W1 on P[2·W1:W1+1]; overflow out of the top bit is discarded.
- The step counter is $clog2(W1+1) bits wide and never wraps during a run.
- Operands `a`, `b`, `sign` are don't-care outside the `start` capture cycle.

## Timing

- Reset values: `busy`=0, `done`=0, `z`=0, state IDLE, P and counter 0.
- If `start` is sampled at edge k:
  - `busy`=1 from edge k to edge k+W1;
  - steps execute at edges k+1 … k+W1;
  - at edge k+W1, `z` updates, `done` goes to 1, and `busy` goes to 0.
- Latency from the start edge to done high is W1 = WIDTH+1 cycles (33 for WIDTH=32). Throughput is one product per W1+1 cycles back-to-back.
- `done` is high for exactly one cycle. `z` is stable from that cycle until the next completion.
- `start` while `busy`=1 is ignored: no queueing, no effect on the running product.
- `start` in the cycle `done`=1 is accepted, since `busy` is already 0. The new run begins; `z` retains the just-completed product until the new run completes.
- Reset asserted mid-run:
  - all outputs clear asynchronously;
  - the partial result is discarded;
  - no `done` is produced for the aborted request.
- `start` held high continuously produces back-to-back products, a new capture each time `busy`=0.

## Test plan

- WIDTH=32, signed: 3 × −5 (0x00000003, 0xFFFFFFFB) -> `z`=0xFFFFFFFF_FFFFFFF1. `done` exactly 33 cycles after the start edge; `busy` high 33 cycles.
- WIDTH=32, signed: 0x80000000 × 0x80000000 -> `z`=0x40000000_00000000. Also 0x80000000 × 0x00000001 -> 0xFFFFFFFF_80000000.
- WIDTH=32, 0xFFFFFFFF × 0xFFFFFFFF:
  - `sign`=0 -> `z`=0xFFFFFFFE_00000001;
  - `sign`=1 -> `z`=0x00000000_00000001.
- Handshake:
  - `start` pulsed again 10 cycles into a run with different operands -> ignored; the first product is returned.
  - `start` asserted on the `done` cycle -> second product returned 33 cycles later.
  - `z` holds between completions.
- Reset mid-run: drive `reset` low at cycle 15 of a run -> `busy`/`done`/`z` go to 0 without waiting for a clock edge. After release, no `done` appears until a new `start`.
- WIDTH=8, signed: −128 × 127 (0x80, 0x7F) -> `z`=0xC080, latency 9. Unsigned 0xFF × 0xFF -> 0xFE01.

Source files
------------

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock over WIDTH+1 steps,
// full 2*WIDTH-bit product for signed or unsigned operands, start/busy/done handshake.
module mult_booth_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sign,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int W1 = WIDTH + 1;
    localparam int PW = 2 * W1 + 1;
    localparam int CW = $clog2(W1 + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [W1-1:0]  r_m;
    logic signed [W1-1:0]  r_m_neg;
    logic [PW-1:0]         r_p;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;
    logic [2*WIDTH-1:0]    r_z;

    logic signed [W1-1:0]  w_ext_a;
    logic signed [W1-1:0]  w_ext_b;
    logic [PW-1:0]         w_p_step;
    logic                  w_last;

    // One Booth step: conditional add on the upper W1 bits, then arithmetic shift right.
    function automatic logic [PW-1:0] booth_step(input logic [PW-1:0] p,
                                                 input logic [W1-1:0] m,
                                                 input logic [W1-1:0] m_neg);
        logic [W1-1:0] hi;
        case (p[1:0])
            2'b01:   hi = p[PW-1:W1+1] + m;
            2'b10:   hi = p[PW-1:W1+1] + m_neg;
            default: hi = p[PW-1:W1+1];
        endcase
        return {hi[W1-1], hi, p[W1:1]};
    endfunction

    // The extra bit makes unsigned operands non-negative so one signed algorithm covers both modes.
    assign w_ext_a  = sign ? {a[WIDTH-1], a} : {1'b0, a};
    assign w_ext_b  = sign ? {b[WIDTH-1], b} : {1'b0, b};
    assign w_p_step = booth_step(r_p, r_m, r_m_neg);
    assign w_last   = (r_cnt == CW'(W1 - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m     <= '0;
            r_m_neg <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_z     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= w_ext_a;
                        r_m_neg <= -w_ext_a;
                        r_p     <= {{W1{1'b0}}, w_ext_b, 1'b0};
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_p   <= w_p_step;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_z    <= w_p_step[2*WIDTH:1];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == RUN);
        done = r_done;
        z    = r_z;
    end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq at WIDTH=32 and WIDTH=8 with a product scoreboard.
module tb_mult_booth_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, sign32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] z32;
    logic        start8, sign8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] z8;

    int checks = 0;
    int errors = 0;

    logic [63:0] q32[$];
    logic [15:0] q8[$];
    logic [63:0] last32 = '0;
    logic [15:0] last8  = '0;
    logic [63:0] e32;
    logic [15:0] e8;

    mult_booth_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(rst_n), .start(start32), .sign(sign32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .z(z32)
    );

    mult_booth_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .sign(sign8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [65:0] ea, eb, p;
        ea = s ? {{34{a[31]}}, a} : {34'd0, a};
        eb = s ? {{34{b[31]}}, b} : {34'd0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [17:0] ea, eb, p;
        ea = s ? {{10{a[7]}}, a} : {10'd0, a};
        eb = s ? {{10{b[7]}}, b} : {10'd0, b};
        p  = ea * eb;
        return p[15:0];
    endfunction

    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", {63'd0, done32}, 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("z32", z32, e32);
                last32 = e32;
            end
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", {63'd0, done8}, 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("z8", {48'd0, z8}, {48'd0, e8});
                last8 = e8;
            end
        end
    end

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input bit inject);
        int lat, bcnt;
        start32 = 1'b1; a32 = a; b32 = b; sign32 = s;
        @(posedge clk);
        q32.push_back(exp);
        #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; sign32 = 1'($urandom);
        lat  = 0;
        bcnt = busy32 ? 1 : 0;
        for (int i = 1; i <= 60; i++) begin
            if (inject && i == 10) begin
                start32 = 1'b1; a32 = 32'h0000_0007; b32 = 32'h0000_0009; sign32 = 1'b0;
            end
            @(posedge clk);
            #1;
            start32 = 1'b0;
            if (i == 16) chk("z32_hold", z32, last32);
            if (done32) begin
                lat = i;
                break;
            end
            if (busy32) bcnt++;
        end
        chk("latency32", 64'(lat), 64'd33);
        chk("busy32_cycles", 64'(bcnt), 64'd33);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp);
        int lat, bcnt;
        start8 = 1'b1; a8 = a; b8 = b; sign8 = s;
        @(posedge clk);
        q8.push_back(exp);
        #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sign8 = 1'($urandom);
        lat  = 0;
        bcnt = busy8 ? 1 : 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) chk("z8_hold", {48'd0, z8}, {48'd0, last8});
            if (done8) begin
                lat = i;
                break;
            end
            if (busy8) bcnt++;
        end
        chk("latency8", 64'(lat), 64'd9);
        chk("busy8_cycles", 64'(bcnt), 64'd9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  sa, sb;
        logic        rs;
        int          dcnt;

        rst_n = 1'b0;
        start32 = 1'b0; sign32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sign8  = 1'b0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy32", {63'd0, busy32}, 64'd0);
        chk("reset_done32", {63'd0, done32}, 64'd0);
        chk("reset_z32", z32, 64'd0);
        chk("reset_busy8", {63'd0, busy8}, 64'd0);
        chk("reset_z8", {48'd0, z8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed products; each run starts in the previous run's done cycle.
        run32(32'h0000_0003, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
        run32(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'(k);
            run32(ra, rb, rs, ref32(ra, rb, rs), 1'b0);
        end

        repeat (6) @(posedge clk);
        #1;
        chk("z32_idle_hold", z32, last32);
        chk("busy32_idle", {63'd0, busy32}, 64'd0);

        // Abort a run with reset in its 15th cycle, away from any clock edge.
        start32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h0000_0005; sign32 = 1'b0;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        chk("busy32_before_abort", {63'd0, busy32}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy32", {63'd0, busy32}, 64'd0);
        chk("abort_done32", {63'd0, done32}, 64'd0);
        chk("abort_z32", z32, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last32 = '0;
        last8  = '0;
        dcnt = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done32 || busy32) dcnt++;
        end
        chk("no_activity_after_abort", 64'(dcnt), 64'd0);
        @(negedge clk);
        run32(32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);

        run8(8'h80, 8'h7F, 1'b1, 16'hC080);
        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8(8'h80, 8'h80, 1'b1, 16'h4000);
        for (int k = 0; k < 4; k++) begin
            sa = 8'($urandom); sb = 8'($urandom); rs = 1'(k);
            run8(sa, sb, rs, ref8(sa, sb, rs));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
